// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: default widths, display limit,
// the measurement FSM states and the gate counter width helper.
package freq_meter_pkg;

  localparam int COUNT_W_DEFAULT = 23;
  localparam int DISPLAY_MAX     = 999_999;

  typedef enum logic {
    FILL  = 1'b0,
    COUNT = 1'b1
  } state_t;

  function automatic int gate_w(input int gate_cycles);
    return $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector on the synchronised level.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/freq_gate_counter.sv
// Gated edge counter: counts synchronised rising edges of sig_in over
// GATE_CYCLES clocks and latches the result into freq_out. Optional macro
// FREQ_CLAMP_EN saturates the count at the six-digit display maximum.
module freq_gate_counter
  import freq_meter_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int GATE_CYCLES = CLK_FREQ,
  parameter int COUNT_W     = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sig_in,
  input  logic               hold,
  output logic [COUNT_W-1:0] freq_out,
  output logic               valid,
  output logic               ovf
);

  localparam int               GW        = gate_w(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
`ifdef FREQ_CLAMP_EN
  localparam logic [COUNT_W-1:0] LIMIT = (COUNT_W >= 20) ? COUNT_W'(DISPLAY_MAX) : '1;
`else
  localparam logic [COUNT_W-1:0] LIMIT = '1;
`endif

  if (GATE_CYCLES < 4 || CLK_FREQ <= 0) begin : g_param_check
    $error("freq_gate_counter: GATE_CYCLES must be >= 4 and CLK_FREQ > 0");
  end

  state_t             state;
  logic               fill_cnt;
  logic [GW-1:0]      gate_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic [COUNT_W-1:0] edge_next;
  logic               gate_last;
  logic               rise;
  logic               sig_sync_unused;

  sync_edge_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .sync (sig_sync_unused),
    .rise (rise)
  );

  // The edge in the terminal cycle is folded into the finishing window.
  assign edge_next = (rise && (edge_cnt != LIMIT)) ? edge_cnt + COUNT_W'(1) : edge_cnt;
  assign gate_last = (gate_cnt == GATE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      freq_out <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        FILL: begin
          fill_cnt <= 1'b1;
          if (fill_cnt) state <= COUNT;
        end
        COUNT: begin
          if (gate_last) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            if (!hold) begin
              freq_out <= edge_next;
              ovf      <= (edge_next == LIMIT);
              valid    <= 1'b1;
            end
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_next;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter with a 100-cycle gate; a 23-bit and a
// 5-bit instance share the same stimulus.
module tb_freq_gate_counter;

  localparam int G = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0;
  logic        hold = 1'b0;
  logic [22:0] freq23;
  logic        valid23;
  logic        ovf23;
  logic [4:0]  freq5;
  logic        valid5;
  logic        ovf5;

  int vectors = 0;
  int miscompares = 0;
  int period = 0;
  int ph = 0;

  freq_gate_counter #(.CLK_FREQ(G), .GATE_CYCLES(G), .COUNT_W(23)) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .hold     (hold),
    .freq_out (freq23),
    .valid    (valid23),
    .ovf      (ovf23)
  );

  freq_gate_counter #(.CLK_FREQ(G), .GATE_CYCLES(G), .COUNT_W(5)) dut5 (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .hold     (hold),
    .freq_out (freq5),
    .valid    (valid5),
    .ovf      (ovf5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (period > 0) begin
      ph = (ph + 1) % period;
      sig_in = (ph >= period / 2);
    end
  endtask

  task automatic set_wave(input int p);
    period = p;
    ph = 0;
    sig_in = 1'b0;
  endtask

  task automatic set_level(input logic l);
    period = 0;
    sig_in = l;
  endtask

  task automatic startup(input string tag);
    int n = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (valid23 || valid5) n++;
    end
    chk({tag, "_fill_valid"}, 32'(n), 32'd0);
  endtask

  task automatic window(input string tag, input logic exp_v, input logic chk_vals,
                        input int e23, input logic eo23, input int e5, input logic eo5,
                        input int rise_at);
    int early = 0;
    for (int i = 1; i <= G; i++) begin
      tick();
      if (i < G && (valid23 || valid5)) early++;
      if (i == rise_at) begin
        period = 0;
        sig_in = 1'b1;
      end
    end
    chk({tag, "_early_valid"}, 32'(early), 32'd0);
    chk({tag, "_valid"}, 32'(valid23), 32'(exp_v));
    chk({tag, "_valid5"}, 32'(valid5), 32'(exp_v));
    if (chk_vals) begin
      chk({tag, "_freq"}, 32'(freq23), 32'(e23));
      chk({tag, "_ovf"}, 32'(ovf23), 32'(eo23));
      chk({tag, "_freq5"}, 32'(freq5), 32'(e5));
      chk({tag, "_ovf5"}, 32'(ovf5), 32'(eo5));
    end
  endtask

  initial begin
    // Power-on reset
    repeat (3) tick();
    chk("rst_freq", 32'(freq23), 32'd0);
    chk("rst_valid", 32'(valid23), 32'd0);
    chk("rst_ovf", 32'(ovf23), 32'd0);
    chk("rst_freq5", 32'(freq5), 32'd0);

    // Period-10 square wave from reset release: first valid 102 cycles later
    rst = 1'b0;
    set_wave(10);
    startup("t1");
    window("t1_w1", 1'b1, 1'b1, 10, 1'b0, 10, 1'b0, -1);
    window("t1_w2", 1'b1, 1'b1, 10, 1'b0, 10, 1'b0, -1);

    // Constant high: no edges, valid keeps pulsing
    set_level(1'b1);
    window("t2_skip", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, -1);
    window("t2_w1", 1'b1, 1'b1, 0, 1'b0, 0, 1'b0, -1);
    window("t2_w2", 1'b1, 1'b1, 0, 1'b0, 0, 1'b0, -1);

    // Maximum rate: 50 edges per window, 5-bit instance saturates at 31
    set_wave(2);
    window("t3_skip", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, -1);
    for (int k = 0; k < 5; k++)
      window($sformatf("t3_w%0d", k), 1'b1, 1'b1, 50, 1'b0, 31, 1'b1, -1);
    set_wave(10);
    window("t3_skip2", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, -1);
    window("t3_rec", 1'b1, 1'b1, 10, 1'b0, 10, 1'b0, -1);

    // Hold across two terminal counts while the input slows to period 20
    hold = 1'b1;
    set_wave(20);
    window("t4_h1", 1'b0, 1'b1, 10, 1'b0, 10, 1'b0, -1);
    window("t4_h2", 1'b0, 1'b1, 10, 1'b0, 10, 1'b0, -1);
    hold = 1'b0;
    window("t4_rel", 1'b1, 1'b1, 5, 1'b0, 5, 1'b0, -1);

    // Asynchronous reset in the middle of a window
    repeat (50) tick();
    rst = 1'b1;
    #1;
    chk("t5_freq", 32'(freq23), 32'd0);
    chk("t5_valid", 32'(valid23), 32'd0);
    chk("t5_ovf", 32'(ovf23), 32'd0);
    chk("t5_freq5", 32'(freq5), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    set_wave(20);
    startup("t5");
    window("t5_w", 1'b1, 1'b1, 5, 1'b0, 5, 1'b0, -1);

    // Edge on the terminal cycle belongs to the finishing window only
    set_level(1'b0);
    window("t6_skip", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, -1);
    window("t6_term", 1'b1, 1'b1, 1, 1'b0, 1, 1'b0, 97);
    window("t6_after", 1'b1, 1'b1, 0, 1'b0, 0, 1'b0, -1);
    // One cycle later the edge lands in the first cycle of the next window
    set_level(1'b0);
    window("t6_pre", 1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 98);
    window("t6_next", 1'b1, 1'b1, 1, 1'b0, 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
